// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//   Fetch-stage next-PC generator. Owns the fetch PC register and a
//   direct-mapped branch target buffer (BTB) with 2-bit saturating
//   counters. Predicts in F and resolves jumps/branches in D. A mispredict
//   redirects fetch and clears IF/ID.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   stall_f           hold the fetch PC (hazard unit)
//   pc_f              current fetch PC
//   pred_taken_f      F-stage taken prediction
//   pred_target_f     F-stage predicted next PC
//   valid_d           D-stage instruction valid
//   jump_d, branch_d  D instruction class (jump has priority)
//   bequal_d          branch condition true
//   pc_d              PC of the D instruction
//   jumpdest_d        jump target
//   branchdest_d      branch target
//   pred_taken_d      prediction carried with the D instruction
//   pred_target_d     predicted target carried with the D instruction
//   flush_d           clear IF/ID (combinational)
//   mispredict_count  saturating count of flushes

module pc_predict_unit #(
    parameter int               WIDTH       = 32,
    parameter int               BTB_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_f,
    output logic [WIDTH-1:0] pc_f,
    output logic             pred_taken_f,
    output logic [WIDTH-1:0] pred_target_f,
    input  logic             valid_d,
    input  logic             jump_d,
    input  logic             branch_d,
    input  logic             bequal_d,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [WIDTH-1:0] jumpdest_d,
    input  logic [WIDTH-1:0] branchdest_d,
    input  logic             pred_taken_d,
    input  logic [WIDTH-1:0] pred_target_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int               IDX     = $clog2(BTB_ENTRIES);
    localparam int               TAG_W   = WIDTH - IDX - 2;
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [WIDTH-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    // ---------------- F-stage lookup ----------------
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic [WIDTH-1:0] pc_f_plus4;

    assign idx_f         = pc_f[IDX+1:2];
    assign tag_f         = pc_f[WIDTH-1:IDX+2];
    assign hit_f         = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
    assign pc_f_plus4    = pc_f + PC_STEP;
    assign pred_taken_f  = hit_f & btb_ctr[idx_f][1];
    assign pred_target_f = hit_f ? btb_target[idx_f] : pc_f_plus4;

    // ---------------- D-stage resolve ----------------
    logic             taken_d;
    logic [WIDTH-1:0] act_target_d;
    logic             mispredict_d;
    logic [WIDTH-1:0] redirect_pc;

    assign taken_d      = jump_d | (branch_d & bequal_d);
    assign act_target_d = jump_d ? jumpdest_d : branchdest_d;
    // A non-control instruction predicted taken falls out of the first
    // term and redirects to pc_d+4 because taken_d is 0.
    assign mispredict_d = (taken_d != pred_taken_d) |
                          (taken_d & pred_taken_d & (pred_target_d != act_target_d));
    assign flush_d      = valid_d & mispredict_d;
    assign redirect_pc  = taken_d ? act_target_d : (pc_d + PC_STEP);

    // ---------------- next PC ----------------
    logic [WIDTH-1:0] pc_next;

    always_comb begin
        pc_next = pc_f_plus4;
        if (flush_d)
            pc_next = redirect_pc;
        else if (stall_f)
            pc_next = pc_f;
        else if (pred_taken_f)
            pc_next = pred_target_f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_f <= RESET_PC;
        else
            pc_f <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            mispredict_count <= '0;
        else if (flush_d && (mispredict_count != {CNT_W{1'b1}}))
            mispredict_count <= mispredict_count + CNT_W'(1);
    end

    // ---------------- BTB update ----------------
    logic [IDX-1:0]   idx_d;
    logic [TAG_W-1:0] tag_d;
    logic             hit_d;
    logic             upd_en;
    logic [1:0]       ctr_old;
    logic [1:0]       ctr_new;

    assign idx_d   = pc_d[IDX+1:2];
    assign tag_d   = pc_d[WIDTH-1:IDX+2];
    assign hit_d   = btb_valid[idx_d] && (btb_tag[idx_d] == tag_d);
    assign upd_en  = valid_d & (jump_d | branch_d);
    assign ctr_old = btb_ctr[idx_d];

    always_comb begin
        ctr_new = 2'b01;
        if (jump_d)
            ctr_new = 2'b11;
        else if (hit_d)
            ctr_new = taken_d ? ((ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'b01)
                              : ((ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'b01);
        else
            ctr_new = taken_d ? 2'b10 : 2'b01;
    end

    // Written at the clock edge only, so a same-cycle lookup at the same
    // index sees the previous contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_ctr[i]    <= 2'b01;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (upd_en) begin
            btb_valid[idx_d]  <= 1'b1;
            btb_tag[idx_d]    <= tag_d;
            btb_target[idx_d] <= act_target_d;
            btb_ctr[idx_d]    <= ctr_new;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, valid_d, jump_d, branch_d, bequal_d, pred_taken_d;
    logic [31:0] pc_d, jumpdest_d, branchdest_d, pred_target_d;
    logic [31:0] pc_f, pred_target_f;
    logic        pred_taken_f, flush_d;
    logic [15:0] cnt16;
    logic [31:0] pc_f_s, pred_target_f_s;
    logic        pred_taken_f_s, flush_d_s;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    pc_predict_unit #(.WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .valid_d(valid_d), .jump_d(jump_d), .branch_d(branch_d), .bequal_d(bequal_d),
        .pc_d(pc_d), .jumpdest_d(jumpdest_d), .branchdest_d(branchdest_d),
        .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
        .flush_d(flush_d), .mispredict_count(cnt16)
    );

    pc_predict_unit #(.WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .pc_f(pc_f_s),
        .pred_taken_f(pred_taken_f_s), .pred_target_f(pred_target_f_s),
        .valid_d(valid_d), .jump_d(jump_d), .branch_d(branch_d), .bequal_d(bequal_d),
        .pc_d(pc_d), .jumpdest_d(jumpdest_d), .branchdest_d(branchdest_d),
        .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
        .flush_d(flush_d_s), .mispredict_count(cnt2)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tg;
        logic        fl;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input int id, input string what, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL step%0d %s: got 0x%08h want 0x%08h", id, what, act, req);
        end
    endtask

    // Monitor: outputs are stable a little after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e.id, "pc_f",          pc_f,                 e.pc);
                check(e.id, "pred_taken_f",  {31'b0, pred_taken_f}, {31'b0, e.pt});
                check(e.id, "pred_target_f", pred_target_f,        e.tg);
                check(e.id, "flush_d",       {31'b0, flush_d},      {31'b0, e.fl});
                check(e.id, "count16",       {16'b0, cnt16},        e.cnt);
                check(e.id, "count2",        {30'b0, cnt2},         (e.cnt > 3) ? 3 : e.cnt);
            end
        end
    end

    task automatic push(input int id, input logic [31:0] epc, input logic ept,
                        input logic [31:0] etg, input logic efl, input int ecnt);
        exp_t e;
        e.id = id; e.pc = epc; e.pt = ept; e.tg = etg; e.fl = efl; e.cnt = ecnt;
        q.push_back(e);
    endtask

    // Called at a falling edge: apply inputs, queue the expectation, move on.
    task automatic cyc(input int id, input logic st, input logic vd, input logic j,
                       input logic b, input logic beq, input logic [31:0] pcd,
                       input logic [31:0] jd, input logic [31:0] bd, input logic ptd,
                       input logic [31:0] ptg, input logic [31:0] epc, input logic ept,
                       input logic [31:0] etg, input logic efl, input int ecnt);
        stall_f = st; valid_d = vd; jump_d = j; branch_d = b; bequal_d = beq;
        pc_d = pcd; jumpdest_d = jd; branchdest_d = bd;
        pred_taken_d = ptd; pred_target_d = ptg;
        push(id, epc, ept, etg, efl, ecnt);
        @(negedge clk);
    endtask

    task automatic idle(input int id, input logic st, input logic [31:0] epc,
                        input logic ept, input logic [31:0] etg, input int ecnt);
        cyc(id, st, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            epc, ept, etg, 1'b0, ecnt);
    endtask

    // Non-control instruction predicted taken: redirects to pcd+4.
    task automatic alias_fix(input int id, input logic st, input logic [31:0] pcd,
                             input logic [31:0] epc, input logic ept,
                             input logic [31:0] etg, input int ecnt);
        cyc(id, st, 1'b1, 1'b0, 1'b0, 1'b0, pcd, 32'h0, 32'h0, 1'b1, 32'h0,
            epc, ept, etg, 1'b1, ecnt);
    endtask

    initial begin
        rst_n = 1'b0;
        stall_f = 0; valid_d = 0; jump_d = 0; branch_d = 0; bequal_d = 0;
        pc_d = 0; jumpdest_d = 0; branchdest_d = 0; pred_taken_d = 0; pred_target_d = 0;
        @(negedge clk);
        push(0, 32'h0, 1'b0, 32'h4, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1, 0, 32'h0, 0, 32'h4, 0);
        idle(2, 0, 32'h4, 0, 32'h8, 0);
        // cold taken branch at 0x10 -> 0x40
        cyc(3, 0, 1, 0, 1, 1, 32'h10, 32'h0, 32'h40, 0, 32'h0, 32'h8, 0, 32'hC, 1, 0);
        idle(4, 0, 32'h40, 0, 32'h44, 1);
        alias_fix(5, 0, 32'hC, 32'h44, 0, 32'h48, 1);
        idle(6, 1, 32'h10, 1, 32'h40, 2);
        // three correctly predicted taken resolves: ctr 10 -> 11 -> 11 -> 11
        for (int k = 0; k < 3; k++)
            cyc(7 + k, 1, 1, 0, 1, 1, 32'h10, 32'h0, 32'h40, 1, 32'h40, 32'h10, 1, 32'h40, 0, 2);
        // first not-taken: ctr 11 -> 10, redirect 0x14
        cyc(10, 1, 1, 0, 1, 0, 32'h10, 32'h0, 32'h40, 1, 32'h40, 32'h10, 1, 32'h40, 1, 2);
        alias_fix(11, 1, 32'hC, 32'h14, 0, 32'h18, 3);
        idle(12, 1, 32'h10, 1, 32'h40, 4);
        // second not-taken: ctr 10 -> 01
        cyc(13, 1, 1, 0, 1, 0, 32'h10, 32'h0, 32'h40, 1, 32'h40, 32'h10, 1, 32'h40, 1, 4);
        alias_fix(14, 1, 32'hC, 32'h14, 0, 32'h18, 5);
        idle(15, 1, 32'h10, 0, 32'h40, 6);
        // same-cycle write at idx 4: lookup still sees ctr 01
        cyc(16, 1, 1, 0, 1, 1, 32'h10, 32'h0, 32'h40, 0, 32'h0, 32'h10, 0, 32'h40, 1, 6);
        // cold jump 0x20 -> 0x100
        cyc(17, 0, 1, 1, 0, 0, 32'h20, 32'h100, 32'h0, 0, 32'h0, 32'h40, 0, 32'h44, 1, 7);
        cyc(18, 0, 1, 1, 0, 0, 32'h20, 32'h100, 32'h0, 1, 32'h100, 32'h100, 0, 32'h104, 0, 8);
        alias_fix(19, 0, 32'h1C, 32'h104, 0, 32'h108, 8);
        idle(20, 0, 32'h20, 1, 32'h100, 9);
        idle(21, 0, 32'h100, 0, 32'h104, 9);
        // stall alone holds
        for (int k = 0; k < 3; k++)
            idle(22 + k, 1, 32'h104, 0, 32'h108, 9);
        idle(25, 0, 32'h104, 0, 32'h108, 9);
        alias_fix(26, 0, 32'h4C, 32'h108, 0, 32'h10C, 9);
        // 0x50 aliases idx 4 with a different tag
        idle(27, 1, 32'h50, 0, 32'h54, 10);
        // jump and branch both set: jump wins, target 0x200
        cyc(28, 1, 1, 1, 1, 0, 32'h20, 32'h200, 32'h300, 1, 32'h100, 32'h50, 0, 32'h54, 1, 10);
        idle(29, 0, 32'h200, 0, 32'h204, 11);
        // top-of-address wrap
        alias_fix(30, 0, 32'hFFFF_FFF8, 32'h204, 0, 32'h208, 11);
        idle(31, 0, 32'hFFFF_FFFC, 0, 32'h0, 12);
        idle(32, 0, 32'h0, 0, 32'h4, 12);
        // reset together with a pending update at 0x30
        rst_n = 1'b0;
        cyc(33, 0, 1, 0, 1, 1, 32'h30, 32'h0, 32'h80, 0, 32'h0, 32'h4, 0, 32'h8, 1, 12);
        rst_n = 1'b1;
        // walk 0x0..0x34: nothing predicted, BTB was cleared
        for (int k = 0; k <= 13; k++)
            idle(34 + k, 0, 32'(4 * k), 0, 32'(4 * k + 4), 0);

        #5;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
